// File: rtl/bfis_pkg.sv
// Shared types for the best-first search vertex streaming path.
package bfis_pkg;

   localparam int unsigned WORD_W = 32;

   typedef logic [WORD_W-1:0] addr_t;
   typedef logic [WORD_W-1:0] coord_t;

   typedef enum logic [2:0] {IDLE, REQ, WAIT, EMIT, GAP} vstx_state_t;

   // Word address of coordinate idx of vertex vaddr; wraps modulo 2^WORD_W.
   function automatic addr_t vstx_word_addr(input addr_t base, input addr_t vaddr,
                                            input addr_t dim, input addr_t idx);
      return base + vaddr * dim + idx;
   endfunction

endpackage

// File: rtl/vstream_addr_fifo.sv
// Pending vertex-address FIFO; DEPTH must be a power of two (>= 2).
module vstream_addr_fifo
   import bfis_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic  clk_in,
   input  logic  rst_in,
   input  logic  push_in,
   input  addr_t push_data_in,
   input  logic  pop_in,
   output addr_t head_out,
   output logic  full_out,
   output logic  empty_out
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [PTR_W:0] r_wr_ptr;
   logic [PTR_W:0] r_rd_ptr;
   addr_t          r_mem [DEPTH];
   logic           w_push;
   logic           w_pop;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign full_out  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                      (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
   assign empty_out = (r_wr_ptr == r_rd_ptr);
   assign w_push    = push_in && !full_out;
   assign w_pop     = pop_in && !empty_out;
   assign head_out  = r_mem[r_rd_ptr[PTR_W-1:0]];

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (w_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= push_data_in;
   end

endmodule

// File: rtl/vertex_stream_tx.sv
// Fetches DIM coordinate words per queued vertex and streams them as contiguous beats.
// Build macro VERTEX_STREAM_DEDUP_EN drops an address equal to the last one streamed.
module vertex_stream_tx
   import bfis_pkg::*;
#(
   parameter int unsigned DIM        = 2,
   parameter addr_t       POS_BASE   = 32'h0,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned GAP_CYCLES = 1
) (
   input  logic   clk_in,
   input  logic   rst_in,
   input  addr_t  addr_in,
   input  logic   addr_valid_in,
   output logic   addr_ready_out,
   output addr_t  mem_req_out,
   output logic   mem_valid_out,
   input  coord_t mem_data_in,
   input  logic   mem_valid_in,
   output coord_t vertex_out,
   output addr_t  vertex_addr_out,
   output logic   vertex_valid_out,
   output logic   busy_out
);

   localparam int unsigned     CT_W     = $clog2(DIM + 1);
   localparam int unsigned     BUF_N    = 1 << CT_W;
   localparam int unsigned     GAP_W    = $clog2(GAP_CYCLES + 1);
   localparam logic [CT_W-1:0] DIM_CT   = CT_W'(DIM);
   localparam logic [CT_W-1:0] LAST_CT  = CT_W'(DIM - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
   localparam addr_t           DIM_A    = addr_t'(DIM);

   vstx_state_t      r_state;
   addr_t            r_cur_addr;
   addr_t            r_mem_req;
   logic             r_mem_valid;
   coord_t           r_vertex_out;
   addr_t            r_vertex_addr;
   logic             r_vertex_valid;
   logic [CT_W-1:0]  r_req_ct;
   logic [CT_W-1:0]  r_rsp_ct;
   logic [CT_W-1:0]  r_emit_ct;
   logic [GAP_W-1:0] r_gap_ct;
   coord_t           r_coord_buf [BUF_N];

   logic             w_full;
   logic             w_empty;
   logic             w_pop;
   logic             w_drop;
   addr_t            w_head;
   logic             w_rsp_fire;
   logic             w_rsp_done;
   logic             w_emit_go;
   coord_t           w_first_word;
   logic [CT_W-1:0]  w_emit_nxt;

   vstream_addr_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_addr_fifo (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .push_in      (addr_valid_in),
      .push_data_in (addr_in),
      .pop_in       (w_pop),
      .head_out     (w_head),
      .full_out     (w_full),
      .empty_out    (w_empty)
   );

   assign w_pop      = (r_state == IDLE) && !w_empty;
   assign w_rsp_fire = mem_valid_in && ((r_state == REQ) || (r_state == WAIT)) &&
                       (r_rsp_ct != DIM_CT);
   assign w_rsp_done = w_rsp_fire && (r_rsp_ct == LAST_CT);
   assign w_emit_go  = w_rsp_done &&
                       ((r_state == WAIT) || ((r_state == REQ) && (r_req_ct == DIM_CT)));
   // With DIM == 1 the only word arrives on the same edge that starts the burst.
   assign w_first_word = (r_rsp_ct == '0) ? mem_data_in : r_coord_buf[0];
   assign w_emit_nxt   = r_emit_ct + 1'b1;

`ifdef VERTEX_STREAM_DEDUP_EN
   logic  r_last_vld;
   addr_t r_last_addr;

   assign w_drop = r_last_vld && (w_head == r_last_addr);

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_last_vld  <= 1'b0;
         r_last_addr <= '0;
      end else if (w_pop && !w_drop) begin
         r_last_vld  <= 1'b1;
         r_last_addr <= w_head;
      end
   end
`else
   assign w_drop = 1'b0;
`endif

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_state        <= IDLE;
         r_cur_addr     <= '0;
         r_mem_req      <= '0;
         r_mem_valid    <= 1'b0;
         r_vertex_out   <= '0;
         r_vertex_addr  <= '0;
         r_vertex_valid <= 1'b0;
         r_req_ct       <= '0;
         r_rsp_ct       <= '0;
         r_emit_ct      <= '0;
         r_gap_ct       <= '0;
         for (int i = 0; i < int'(BUF_N); i++) r_coord_buf[i] <= '0;
      end else begin
         r_mem_valid <= 1'b0;
         if (w_rsp_fire) begin
            r_coord_buf[r_rsp_ct] <= mem_data_in;
            r_rsp_ct              <= r_rsp_ct + 1'b1;
         end
         unique case (r_state)
            IDLE: begin
               if (w_pop && !w_drop) begin
                  r_cur_addr  <= w_head;
                  r_rsp_ct    <= '0;
                  r_req_ct    <= CT_W'(1);
                  r_mem_valid <= 1'b1;
                  r_mem_req   <= vstx_word_addr(POS_BASE, w_head, DIM_A, '0);
                  r_state     <= REQ;
               end
            end
            REQ: begin
               if (r_req_ct == DIM_CT) begin
                  r_state <= WAIT;
               end else begin
                  r_mem_valid <= 1'b1;
                  r_mem_req   <= vstx_word_addr(POS_BASE, r_cur_addr, DIM_A, addr_t'(r_req_ct));
                  r_req_ct    <= r_req_ct + 1'b1;
               end
            end
            WAIT: ;
            EMIT: begin
               if (r_emit_ct == LAST_CT) begin
                  r_vertex_valid <= 1'b0;
                  r_gap_ct       <= '0;
                  r_state        <= GAP;
               end else begin
                  r_vertex_out <= r_coord_buf[w_emit_nxt];
                  r_emit_ct    <= w_emit_nxt;
               end
            end
            GAP: begin
               if (r_gap_ct == GAP_LAST) r_state <= IDLE;
               else                      r_gap_ct <= r_gap_ct + 1'b1;
            end
            default: r_state <= IDLE;
         endcase
         // All DIM words are buffered: release the whole burst at once.
         if (w_emit_go) begin
            r_state        <= EMIT;
            r_emit_ct      <= '0;
            r_vertex_valid <= 1'b1;
            r_vertex_out   <= w_first_word;
            r_vertex_addr  <= r_cur_addr;
         end
      end
   end

   assign addr_ready_out   = !w_full;
   assign mem_req_out      = r_mem_req;
   assign mem_valid_out    = r_mem_valid;
   assign vertex_out       = r_vertex_out;
   assign vertex_addr_out  = r_vertex_addr;
   assign vertex_valid_out = r_vertex_valid;
   assign busy_out         = (r_state != IDLE) || !w_empty;

endmodule

// File: tb/tb_vertex_stream_tx.sv
// Directed bench for vertex_stream_tx with a latency-configurable memory model and scoreboard.
module tb_vertex_stream_tx;
   import bfis_pkg::*;

   localparam int unsigned DIM        = 2;
   localparam logic [31:0] POS_BASE   = 32'h100;
   localparam int unsigned FIFO_DEPTH = 4;
   localparam int unsigned GAP_CYCLES = 1;
   localparam logic [31:0] MAGIC      = 32'hA5A5_0000;

   logic        clk_in;
   logic        rst_in;
   logic [31:0] addr_in;
   logic        addr_valid_in;
   logic        addr_ready_out;
   logic [31:0] mem_req_out;
   logic        mem_valid_out;
   logic [31:0] mem_data_in;
   logic        mem_valid_in;
   logic [31:0] vertex_out;
   logic [31:0] vertex_addr_out;
   logic        vertex_valid_out;
   logic        busy_out;

   vertex_stream_tx #(
      .DIM        (DIM),
      .POS_BASE   (POS_BASE),
      .FIFO_DEPTH (FIFO_DEPTH),
      .GAP_CYCLES (GAP_CYCLES)
   ) dut (
      .clk_in           (clk_in),
      .rst_in           (rst_in),
      .addr_in          (addr_in),
      .addr_valid_in    (addr_valid_in),
      .addr_ready_out   (addr_ready_out),
      .mem_req_out      (mem_req_out),
      .mem_valid_out    (mem_valid_out),
      .mem_data_in      (mem_data_in),
      .mem_valid_in     (mem_valid_in),
      .vertex_out       (vertex_out),
      .vertex_addr_out  (vertex_addr_out),
      .vertex_valid_out (vertex_valid_out),
      .busy_out         (busy_out)
   );

   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   int          n_chk = 0;
   int          n_pass = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          n_beats = 0;
   int          run_len = 0;
   int          last_rsp_cyc = -1;
   int          last_due = 0;
   int          mem_lat = 1;
   int          mem_gap = 0;
   bit          mem_hold = 1'b0;
   logic [31:0] q_req[$];
   logic [31:0] q_dat[$];
   logic [31:0] q_vad[$];
   logic [31:0] pend_dat[$];
   int          pend_due[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic bchk(input string tag, input bit cond);
      chk(tag, {31'b0, cond}, 32'd1);
   endtask

   // Independent 64-bit reference for the coordinate word address, truncated afterwards.
   function automatic logic [31:0] exp_req(input logic [31:0] a, input int k);
      logic [63:0] w;
      w = 64'(POS_BASE) + 64'(a) * 64'(DIM) + 64'(k);
      return w[31:0];
   endfunction

   task automatic expect_vertex(input logic [31:0] a);
      for (int k = 0; k < int'(DIM); k++) begin
         q_req.push_back(exp_req(a, k));
         q_dat.push_back(exp_req(a, k) ^ MAGIC);
         q_vad.push_back(a);
      end
   endtask

   task automatic push_addr(input logic [31:0] a, input bit streamed);
      int i;
      @(negedge clk_in);
      addr_in       = a;
      addr_valid_in = 1'b1;
      i = 0;
      while (i < 300 && !addr_ready_out) begin
         @(negedge clk_in);
         i++;
      end
      chk("push_ready", {31'b0, addr_ready_out}, 32'd1);
      if (streamed) expect_vertex(a);
      @(posedge clk_in);
      #1 addr_valid_in = 1'b0;
   endtask

   task automatic drain(input string tag);
      int i;
      i = 0;
      while (i < 400 && (q_dat.size() != 0 || q_req.size() != 0 || pend_due.size() != 0 ||
                         busy_out)) begin
         @(negedge clk_in);
         i++;
      end
      bchk({tag, "_done_in_time"}, i < 400);
      chk({tag, "_beats_left"}, 32'(q_dat.size()), 32'd0);
   endtask

   // Monitor and memory model share one process so cycle bookkeeping stays race-free.
   initial begin
      int          due;
      logic [31:0] d;
      logic [31:0] a;
      mem_valid_in = 1'b0;
      mem_data_in  = '0;
      forever begin
         @(negedge clk_in);
         cyc++;
         if (vertex_valid_out) begin
            bchk("beat_run_not_too_long", run_len < int'(DIM));
            if (run_len == 0) bchk("beat_after_all_words", cyc > last_rsp_cyc);
            run_len++;
            n_beats++;
            bchk("beat_expected", q_dat.size() > 0);
            if (q_dat.size() > 0) begin
               d = q_dat.pop_front();
               a = q_vad.pop_front();
               chk("vertex_out", vertex_out, d);
               chk("vertex_addr_out", vertex_addr_out, a);
            end
         end else begin
            if (run_len != 0) chk("beat_run_len", 32'(run_len), 32'(DIM));
            run_len = 0;
         end
         if (mem_valid_out) begin
            bchk("req_expected", q_req.size() > 0);
            if (q_req.size() > 0) chk("mem_req_out", mem_req_out, q_req.pop_front());
         end
         if (!mem_hold && pend_due.size() > 0 && pend_due[0] <= cyc) begin
            mem_valid_in = 1'b1;
            mem_data_in  = pend_dat.pop_front();
            void'(pend_due.pop_front());
            last_rsp_cyc = cyc;
         end else begin
            mem_valid_in = 1'b0;
         end
         if (rst_in && mem_valid_out) begin
            due = cyc + mem_lat;
            if (due <= last_due + mem_gap) due = last_due + mem_gap + 1;
            pend_due.push_back(due);
            pend_dat.push_back(mem_req_out ^ MAGIC);
            last_due = due;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int beats0;
      addr_in       = '0;
      addr_valid_in = 1'b0;
      rst_in        = 1'b1;
      #2 rst_in     = 1'b0;
      repeat (3) @(negedge clk_in);
      chk("rst_ready", {31'b0, addr_ready_out}, 32'd1);
      chk("rst_busy", {31'b0, busy_out}, 32'd0);
      chk("rst_vvalid", {31'b0, vertex_valid_out}, 32'd0);
      chk("rst_mvalid", {31'b0, mem_valid_out}, 32'd0);
      chk("rst_vout", vertex_out, 32'd0);
      chk("rst_vaddr", vertex_addr_out, 32'd0);
      chk("rst_mreq", mem_req_out, 32'd0);
      rst_in = 1'b1;

      // Basic stream with first-beat latency measured from the push edge.
      @(negedge clk_in);
      addr_in       = 32'd5;
      addr_valid_in = 1'b1;
      chk("basic_ready", {31'b0, addr_ready_out}, 32'd1);
      expect_vertex(32'd5);
      @(posedge clk_in);
      #1 addr_valid_in = 1'b0;
      lat = 0;
      for (int k = 1; k <= 30 && lat == 0; k++) begin
         if (k > 1) @(posedge clk_in);
         else       @(posedge clk_in);
         #1;
         if (vertex_valid_out) lat = k;
      end
      chk("first_beat_latency", 32'(lat), 32'(2 + DIM));
      drain("basic");

      // Back-to-back pushes.
      push_addr(32'd3, 1'b1);
      push_addr(32'd7, 1'b1);
      push_addr(32'd9, 1'b1);
      drain("b2b");

      // Full FIFO while memory is silent.
      mem_hold = 1'b1;
      for (int i = 0; i < 5; i++) push_addr(32'h40 + 32'(i), 1'b1);
      chk("full_ready_low", {31'b0, addr_ready_out}, 32'd0);
      @(negedge clk_in);
      addr_in       = 32'h45;
      addr_valid_in = 1'b1;
      repeat (6) @(negedge clk_in);
      chk("full_still_blocked", {31'b0, addr_ready_out}, 32'd0);
      chk("full_busy", {31'b0, busy_out}, 32'd1);
      mem_hold = 1'b0;
      lat = 0;
      while (lat < 100 && !addr_ready_out) begin
         @(negedge clk_in);
         lat++;
      end
      chk("full_ready_returns", {31'b0, addr_ready_out}, 32'd1);
      expect_vertex(32'h45);
      @(posedge clk_in);
      #1 addr_valid_in = 1'b0;
      drain("full");

      // Slow memory with spaced responses.
      mem_lat = 10;
      mem_gap = 3;
      push_addr(32'h21, 1'b1);
      drain("stall");

      // Asynchronous reset while waiting for responses.
      push_addr(32'h33, 1'b1);
      repeat (5) @(negedge clk_in);
      chk("wait_busy", {31'b0, busy_out}, 32'd1);
      #2 rst_in = 1'b0;
      #1;
      chk("arst_vvalid", {31'b0, vertex_valid_out}, 32'd0);
      chk("arst_mvalid", {31'b0, mem_valid_out}, 32'd0);
      chk("arst_ready", {31'b0, addr_ready_out}, 32'd1);
      chk("arst_busy", {31'b0, busy_out}, 32'd0);
      chk("arst_vout", vertex_out, 32'd0);
      chk("arst_vaddr", vertex_addr_out, 32'd0);
      q_req.delete();
      q_dat.delete();
      q_vad.delete();
      beats0 = n_beats;
      repeat (2) @(negedge clk_in);
      rst_in = 1'b1;
      drain("post_reset");
      repeat (4) @(negedge clk_in);
      chk("no_beat_after_reset", 32'(n_beats), 32'(beats0));
      mem_lat = 1;
      mem_gap = 0;

      // Repeated address.
      push_addr(32'd4, 1'b1);
`ifdef VERTEX_STREAM_DEDUP_EN
      push_addr(32'd4, 1'b0);
`else
      push_addr(32'd4, 1'b1);
`endif
      push_addr(32'd6, 1'b1);
      drain("dedup");

      // Address arithmetic wraps; outputs hold once the burst ends.
      push_addr(32'hFFFF_FFFF, 1'b1);
      drain("wrap");
      chk("hold_vaddr", vertex_addr_out, 32'hFFFF_FFFF);
      chk("hold_vout", vertex_out, exp_req(32'hFFFF_FFFF, int'(DIM) - 1) ^ MAGIC);
      chk("hold_vvalid", {31'b0, vertex_valid_out}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/vertex_stream_tx.md
Name: vertex_stream_tx

Overview:
- Transmit side of the vertex coordinate stream consumed by the best-first search engine.
- Accepts vertex addresses, fetches the DIM coordinate words of each vertex from a graph memory read port, and buffers them.
- Emits each vertex as DIM back-to-back beats on vertex_out/vertex_addr_out/vertex_valid_out, followed by a mandatory idle gap.
- The receiver has no backpressure, so beats are released only once all DIM words are buffered.

Parameters:
- DIM, 2, coordinates per vertex (beats per vertex), >=1
- POS_BASE, 32'h0, word address of vertex 0 coordinate 0
- FIFO_DEPTH, 4, pending-address FIFO entries, power of two
- GAP_CYCLES, 1, idle cycles after the last beat of a vertex, >=1

Ports:
- clk_in  input  1  clock, rising edge
- rst_in  input  1  reset; asynchronous assert, active-low (0 = reset)
- addr_in  input  32  vertex address to stream
- addr_valid_in  input  1  addr_in valid
- addr_ready_out  output  1  FIFO not full; a transfer occurs on valid&&ready
- mem_req_out  output  32  memory word address
- mem_valid_out  output  1  single-cycle read request strobe
- mem_data_in  input  32  read data
- mem_valid_in  input  1  read data valid; responses return in request order
- vertex_out  output  32  coordinate word
- vertex_addr_out  output  32  vertex address, held for all DIM beats
- vertex_valid_out  output  1  beat valid
- busy_out  output  1  FSM not in IDLE, or FIFO not empty

Behaviour:
- Reset (rst_in=0, asynchronous):
  - All outputs 0, except addr_ready_out=1.
  - FIFO emptied, FSM to IDLE, counters cleared.
  - Reset mid-fetch discards in-flight responses; any mem_valid_in arriving after reset release while in IDLE is ignored.
- Address FIFO:
  - addr_ready_out = !full.
  - Simultaneous push and pop while full is not allowed, because ready is low.
  - Simultaneous push and pop while empty is allowed; the popped entry is the old head only.
- FSM states: IDLE, REQ, WAIT, EMIT, GAP.
  - IDLE: if FIFO not empty, pop, latch cur_addr, clear req_ct and rsp_ct, go to REQ.
  - REQ: one request per cycle; mem_req_out = POS_BASE + cur_addr*DIM + req_ct, truncated mod 2^32. After DIM requests go to WAIT; if all responses are already in, go straight to EMIT.
  - Responses are accepted in REQ and WAIT; each writes coord_buf[rsp_ct] and increments rsp_ct. When rsp_ct reaches DIM, go to EMIT.
  - EMIT: DIM consecutive cycles with vertex_valid_out=1, vertex_out=coord_buf[k] for k=0..DIM-1, and vertex_addr_out=cur_addr. Then go to GAP.
  - GAP: vertex_valid_out=0 for GAP_CYCLES cycles, then return to IDLE.
- mem_valid_in outside REQ/WAIT is ignored.
- Minimum latency:
  - With a one-cycle memory, the first beat comes 2+DIM cycles after the FIFO push.
  - Throughput is at most one vertex per 1+DIM+latency+DIM+GAP_CYCLES cycles.
- vertex_addr_out and vertex_out hold their last values while vertex_valid_out=0.

Optional Feature:
- Macro: VERTEX_STREAM_DEDUP_EN.
- When defined:
  - On pop in IDLE, an address equal to the last streamed address (tracked by a valid flag, cleared at reset) is dropped with no memory traffic.
  - The FSM stays in IDLE and may pop again on the next cycle.
- When undefined: every accepted address is streamed.

Decomposition:
- Package bfis_pkg:
  - addr_t and coord_t (logic [31:0]).
  - vstx_state_t enum {IDLE, REQ, WAIT, EMIT, GAP}.
  - Localparam WORD_W=32.
- Sub-module vstream_addr_fifo: parameterized synchronous FIFO with the same clk_in/rst_in, exposing full, empty, push, pop, and head.
- The top level holds the FSM, counters, and coord_buf.

Test Plan:
- Basic stream: DIM=2, POS_BASE=0x100, push addr 5, memory returns 0xA then 0xB -> requests 0x10A then 0x10B; beats 0xA,0xB with vertex_addr_out=5 on consecutive cycles; then >=1 idle cycle.
- Back-to-back addresses: push 3,7,9 with no gaps -> ready stays high; three vertices emitted in order 3,7,9, each separated by GAP_CYCLES idle cycles.
- Full FIFO: hold the memory silent, push 5 addresses with FIFO_DEPTH=4 -> addr_ready_out=0 after the 5th push is absorbed (one entry popped into the FSM); the 6th valid is not accepted until memory responds.
- Memory stall: delay responses 10 cycles and return them one at a time with gaps -> no vertex_valid_out until both words are in, then exactly DIM contiguous beats.
- Reset mid-operation: assert rst_in=0 in WAIT -> all outputs 0 and addr_ready_out=1 asynchronously; a late mem_valid_in after release produces no beat.
- Dedup (with VERTEX_STREAM_DEDUP_EN): push 4,4,6 -> vertices 4 and 6 are emitted and the second 4 issues no memory request. Without the macro, 4,4,6 are all emitted.
